recip_sched: RTL and testbench
==============================

Name: recip_sched

Overview:
- Shares one iterative Newton-Raphson reciprocal unit (recip: start/done, Q9.55 X_in/D_in, 4 iterations) between NREQ requesters, e.g. FP divide and sqrt front-ends.
- Round-robin arbitrates valid/ready requests, checks the divisor range and generates the seed X0 from a LUT.
- Sequences start/done on the unit, supervises it with a watchdog, and returns the tagged result on one shared response channel.

Parameters:
- NREQ, 4, number of requesters (2..8)
- TAG_W, 4, requester-supplied tag width
- TIMEOUT_CYC, 16, max cycles in WAIT before error (must exceed recip latency of 5)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (combinational, one-hot or zero)
- req_d  in  NREQ*64  flattened Q9.55 divisors, slice i = [64*i+63:64*i]
- req_tag  in  NREQ*TAG_W  flattened tags
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  $clog2(NREQ)  index of the requester served
- resp_tag  out  TAG_W  tag echoed from the request
- resp_data  out  64  Q9.55 reciprocal, 0 on error
- resp_err  out  1  1 = range error or timeout
- recip_start  out  1  one-cycle start pulse to the reciprocal unit
- recip_x  out  64  seed X0, Q9.55
- recip_d  out  64  divisor, Q9.55
- recip_result  in  64  reciprocal from the unit
- recip_done  in  1  result-valid pulse from the unit

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; rr_ptr = 0; all latches cleared.
- Reset mid-operation:
  - Aborts immediately; any pending response is discarded.
  - Any later recip_done is ignored (see WAIT).
- FSM states: IDLE, CHECK, ISSUE, WAIT, RESP.
- IDLE:
  - Winner g = first i with req_valid[i], searching from rr_ptr upward with wrap.
  - req_ready[g] = 1 combinationally, only in IDLE.
  - On the handshake: latch d = req_d[g], tag, id = g, then go to CHECK.
  - No valid requests: stay in IDLE.
- CHECK:
  - Range is valid iff d[63:56] == 0 and d[55] == 1, i.e. D in [1,2).
  - Invalid: resp_err = 1, resp_data = 0, go to RESP.
  - Valid: go to ISSUE.
- ISSUE:
  - recip_start = 1 for exactly one cycle.
  - recip_d = d; recip_x = SEED_LUT[d[54:51]].
  - Clear the watchdog counter, go to WAIT.
- WAIT:
  - recip_x and recip_d are held stable.
  - On recip_done: resp_data = recip_result, resp_err = 0, go to RESP.
  - Otherwise the counter increments. At TIMEOUT_CYC: resp_err = 1, resp_data = 0, go to RESP.
  - recip_done in any other state is ignored.
  - If done and the timeout coincide, done wins.
- RESP:
  - resp_valid = 1; all resp_* fields stable until resp_ready.
  - On the handshake: rr_ptr = (id + 1) mod NREQ, return to IDLE.
  - No new grant while in RESP.
- Latency (valid D, recip latency 5): request accept at cycle 0, CHECK 1, ISSUE 2, done at 7, resp_valid at 8.
  - Minimum accept-to-accept is 9 cycles with resp_ready held high.
- Fairness: a continuously-valid requester waits at most NREQ-1 other services.
- Requester contract: req_d and req_tag must be held stable while req_valid is high and not yet accepted.
- Arithmetic:
  - Q9.55: integer bits [63:55], fraction bits [54:0].
  - SEED_LUT[i] = round(2^55 / (1 + (2i+1)/32)), 16 entries. Initial relative error is at most 2^-5, so 4 iterations converge to full precision.

Decomposition:
- Package recip_sched_pkg holds:
  - Q_FRAC = 55, Q_WIDTH = 64.
  - The state enum.
  - The SEED_LUT constant array, 16 x 64.
  - A range-check function.
- Sub-module rr_arbiter (NREQ): inputs req, ptr, enable; outputs one-hot grant and a binary index. It is purely combinational; rr_ptr is stored in recip_sched.

Test Plan:
- Divisor 1.0: req 0 with D = 64'h0080_0000_0000_0000, behavioural recip model -> resp_data within 2^-50 of 64'h0080_0000_0000_0000, resp_id 0, resp_err 0, resp_valid 8 cycles after accept.
- Divisor 1.5: req 2, tag 4'hA, D = 64'h00C0_0000_0000_0000 -> recip_x = SEED_LUT[8]; resp_data within 2^-50 of 64'h0055_5555_5555_5555; resp_tag 4'hA.
- Range errors: D = 0 and D = 64'h0100_0000_0000_0000 -> resp_err 1, resp_data 0, recip_start never asserted.
- Round-robin: all 4 requesters valid continuously -> grant order 0,1,2,3,0. With only requesters 1 and 3 valid -> 1,3,1,3.
- Backpressure: resp_ready low for 10 cycles -> resp_* fields stable, req_ready all 0, no recip_start. Release -> next grant on the following cycle.
- Timeout and reset: recip model never pulses done -> resp_err 1 after 16 WAIT cycles, and a late done is ignored. Separately, reset_n asserted in WAIT -> all outputs 0, the next request is served normally starting from rr_ptr 0.

Source files
------------

// File: rtl/recip_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : recip_sched_pkg
// Brief    : Shared state encoding, Q9.55 constants and X0 seed table.
// Revision : 1.0
// ============================================================================
package recip_sched_pkg;

    localparam int Q_FRAC  = 55;
    localparam int Q_WIDTH = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // round(2^55 / (1 + (2i+1)/32)) rewritten as round(2^60 / (33 + 2i))
    function automatic logic [Q_WIDTH-1:0] seed_entry(input int idx);
        logic [Q_WIDTH-1:0] k;
        k = Q_WIDTH'(33 + 2 * idx);
        return ((64'd1 << (Q_FRAC + 6)) + k) / (k << 1);
    endfunction

    localparam logic [Q_WIDTH-1:0] SEED_LUT [16] = '{
        seed_entry(0),  seed_entry(1),  seed_entry(2),  seed_entry(3),
        seed_entry(4),  seed_entry(5),  seed_entry(6),  seed_entry(7),
        seed_entry(8),  seed_entry(9),  seed_entry(10), seed_entry(11),
        seed_entry(12), seed_entry(13), seed_entry(14), seed_entry(15)
    };

    // Divisor must lie in [1,2): no integer bits above the leading one.
    function automatic logic d_in_range(input logic [Q_WIDTH-1:0] d);
        return (d[63:56] == 8'd0) && d[55];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick starting at ptr, wrapping upward.
// Revision : 1.0
// ============================================================================
module rr_arbiter
    import recip_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    always_comb begin
        int   j;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
        if (enable && found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/recip_sched.sv
`default_nettype none
// ============================================================================
// Module   : recip_sched
// Brief    : Arbitrates requesters onto one Newton-Raphson reciprocal unit.
// Revision : 1.0
// ============================================================================
module recip_sched
    import recip_sched_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*64-1:0]        req_d,
    input  logic [NREQ*TAG_W-1:0]     req_tag,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [$clog2(NREQ)-1:0]   resp_id,
    output logic [TAG_W-1:0]          resp_tag,
    output logic [63:0]               resp_data,
    output logic                      resp_err,
    output logic                      recip_start,
    output logic [63:0]               recip_x,
    output logic [63:0]               recip_d,
    input  logic [63:0]               recip_result,
    input  logic                      recip_done
);

    localparam int IDW = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    state_t               state;
    state_t               state_nx;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       win_idx;
    logic [NREQ-1:0]      grant;
    logic                 arb_en;
    logic                 accept;
    logic                 wd_expire;
    logic [IDW-1:0]       cur_id;
    logic [TAG_W-1:0]     cur_tag;
    logic [Q_WIDTH-1:0]   cur_d;
    logic [Q_WIDTH-1:0]   x_r;
    logic [Q_WIDTH-1:0]   d_r;
    logic [Q_WIDTH-1:0]   data_r;
    logic                 err_r;
    logic [WDW-1:0]       wd_cnt;

    // Grants are suppressed while reset is held so every output reads 0.
    assign arb_en = (state == ST_IDLE) && reset_n;

    rr_arbiter #(
        .NREQ   (NREQ),
        .IDW    (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .enable (arb_en),
        .grant  (grant),
        .idx    (win_idx)
    );

    assign req_ready   = grant;
    assign accept      = |(grant & req_valid);
    assign wd_expire   = (wd_cnt + WDW'(1)) == WDW'(TIMEOUT_CYC);

    assign recip_start = (state == ST_ISSUE);
    assign recip_x     = x_r;
    assign recip_d     = d_r;
    assign resp_valid  = (state == ST_RESP);
    assign resp_id     = cur_id;
    assign resp_tag    = cur_tag;
    assign resp_data   = data_r;
    assign resp_err    = err_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (accept) state_nx = ST_CHECK;
            ST_CHECK: state_nx = d_in_range(cur_d) ? ST_ISSUE : ST_RESP;
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT:  if (recip_done || wd_expire) state_nx = ST_RESP;
            ST_RESP:  if (resp_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr  <= '0;
            cur_id  <= '0;
            cur_tag <= '0;
            cur_d   <= '0;
            x_r     <= '0;
            d_r     <= '0;
            data_r  <= '0;
            err_r   <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cur_d   <= req_d[int'(win_idx)*Q_WIDTH +: Q_WIDTH];
                        cur_tag <= req_tag[int'(win_idx)*TAG_W +: TAG_W];
                        cur_id  <= win_idx;
                    end
                end
                ST_CHECK: begin
                    if (d_in_range(cur_d)) begin
                        d_r <= cur_d;
                        x_r <= SEED_LUT[cur_d[54:51]];
                    end else begin
                        err_r  <= 1'b1;
                        data_r <= '0;
                    end
                end
                ST_ISSUE: begin
                    wd_cnt <= '0;
                end
                ST_WAIT: begin
                    // A done arriving on the expiry cycle still delivers data.
                    if (recip_done) begin
                        data_r <= recip_result;
                        err_r  <= 1'b0;
                    end else if (wd_expire) begin
                        data_r <= '0;
                        err_r  <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WDW'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        rr_ptr <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + IDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_recip_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_recip_sched
// Brief    : Self-checking bench with a spec-level model of recip_sched.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_recip_sched;

    localparam int NREQ        = 4;
    localparam int TAG_W       = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int IDW         = 2;
    localparam logic [63:0] ONE  = 64'h0080_0000_0000_0000;
    localparam logic [63:0] ONE5 = 64'h00C0_0000_0000_0000;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*64-1:0]     req_d;
    logic [NREQ*TAG_W-1:0]  req_tag;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [IDW-1:0]         resp_id;
    logic [TAG_W-1:0]       resp_tag;
    logic [63:0]            resp_data;
    logic                   resp_err;
    logic                   recip_start;
    logic [63:0]            recip_x;
    logic [63:0]            recip_d;
    logic [63:0]            recip_result;
    logic                   recip_done;

    always #5 clk = ~clk;

    recip_sched #(
        .NREQ(NREQ), .TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_d(req_d), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_tag(resp_tag), .resp_data(resp_data), .resp_err(resp_err),
        .recip_start(recip_start), .recip_x(recip_x), .recip_d(recip_d),
        .recip_result(recip_result), .recip_done(recip_done)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_near(input string nm, input logic [63:0] act, input logic [63:0] exp,
                            input int tol);
        logic [63:0] diff;
        n_vec++;
        diff = (act > exp) ? act - exp : exp - act;
        if ($isunknown(act) || diff > 64'(tol)) begin
            n_err++;
            $display("FAIL %s: actual %h required %h +/- %0d (cycle %0d)", nm, act, exp, tol, cyc);
        end
    endtask

    // Reference arithmetic
    function automatic logic [63:0] seed_model(input int i);
        logic [127:0] num;
        logic [127:0] den;
        num = 128'd1 << 60;
        den = 128'(33 + 2 * i);
        return 64'((num + den / 2) / den);
    endfunction

    function automatic logic [63:0] recip_model(input logic [63:0] d);
        logic [127:0] num;
        num = 128'd1 << 110;
        return 64'(num / 128'(d));
    endfunction

    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int ptr);
        logic [NREQ-1:0] g;
        g = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (v[j] && g == '0) g[j] = 1'b1;
        end
        return g;
    endfunction

    typedef struct {
        int              id;
        logic [TAG_W-1:0] tag;
        logic [63:0]     d;
        bit              inrange;
        bit              err;
        logic [63:0]     data;
        int              acc;
        int              lat;
    } exp_t;

    exp_t        cur;
    bit          busy = 1'b0;
    bit          first_seen = 1'b0;
    int          m_ptr = 0;
    int          gq[$];
    int          aq[$];
    int          starts = 0;
    int          served = 0;
    int          last_lat = 0;
    int          last_id = 0;
    int          last_hs = 0;
    int          last_acc = 0;
    logic [63:0] last_x = '0;
    logic [63:0] last_data = '0;
    logic        last_err = 1'b0;
    logic [TAG_W-1:0] last_tag = '0;
    int          recip_mode = 0;
    int          late_req = 0;
    int          late_ack = 0;

    // Directed checks from the stimulus thread are routed through here.
    string       d_name;
    logic [63:0] d_act;
    logic [63:0] d_exp;
    int          d_tol;
    int          d_req = 0;
    int          d_ack = 0;

    always @(negedge clk) begin : p_cmp
        logic [NREQ-1:0] eg;
        bit              es;
        if (d_req != d_ack) begin
            if (d_tol == 0) chk(d_name, d_act, d_exp);
            else            chk_near(d_name, d_act, d_exp, d_tol);
            d_ack = d_req;
        end
        if (!reset_n) begin
            chk("rst_ctl", 64'({req_ready, resp_valid, resp_err, recip_start, resp_id, resp_tag}), 64'd0);
            chk("rst_resp_data", resp_data, 64'd0);
            chk("rst_recip_x", recip_x, 64'd0);
            chk("rst_recip_d", recip_d, 64'd0);
            busy  = 1'b0;
            m_ptr = 0;
        end else begin
            eg = busy ? '0 : rr_pick(req_valid, m_ptr);
            chk("req_ready", 64'(req_ready), 64'(eg));
            es = busy && cur.inrange && (cyc == cur.acc + 2);
            chk("recip_start", 64'(recip_start), 64'(es));
            if (recip_start) begin
                starts++;
                last_x = recip_x;
            end
            if (busy && cur.inrange && cyc >= cur.acc + 2 && cyc < cur.acc + cur.lat) begin
                chk("recip_x", recip_x, seed_model(int'(cur.d[54:51])));
                chk("recip_d", recip_d, cur.d);
            end
            chk("resp_valid", 64'(resp_valid), 64'(busy && cyc >= cur.acc + cur.lat));
            if (resp_valid && busy) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    last_lat   = cyc - cur.acc;
                end
                chk("resp_id", 64'(resp_id), 64'(cur.id));
                chk("resp_tag", 64'(resp_tag), 64'(cur.tag));
                chk("resp_err", 64'(resp_err), 64'(cur.err));
                if (cur.err) chk("resp_data", resp_data, 64'd0);
                else         chk_near("resp_data", resp_data, cur.data, 32);
                if (resp_ready) begin
                    busy      = 1'b0;
                    m_ptr     = (cur.id + 1) % NREQ;
                    served++;
                    last_hs   = cyc;
                    last_id   = cur.id;
                    last_tag  = resp_tag;
                    last_data = resp_data;
                    last_err  = resp_err;
                end
            end
            if (|(req_valid & eg)) begin
                for (int j = 0; j < NREQ; j++) begin
                    if (eg[j]) begin
                        cur.id  = j;
                        cur.tag = req_tag[j*TAG_W +: TAG_W];
                        cur.d   = req_d[j*64 +: 64];
                    end
                end
                cur.inrange = (cur.d[63:56] == 8'd0) && cur.d[55];
                cur.acc     = cyc;
                if (!cur.inrange) begin
                    cur.err = 1'b1; cur.data = '0; cur.lat = 2;
                end else if (recip_mode != 0) begin
                    cur.err = 1'b1; cur.data = '0; cur.lat = 3 + TIMEOUT_CYC;
                end else begin
                    cur.err = 1'b0; cur.data = recip_model(cur.d); cur.lat = 8;
                end
                busy       = 1'b1;
                first_seen = 1'b0;
                last_acc   = cyc;
                gq.push_back(cur.id);
                aq.push_back(cyc);
            end
        end
    end

    // Reciprocal unit: fixed 5-cycle latency, or silent when recip_mode != 0.
    bit          pend = 1'b0;
    int          done_cyc = 0;
    logic [63:0] pd = '0;
    always @(negedge clk) begin : p_recip
        recip_done   = 1'b0;
        recip_result = '0;
        if (late_req != late_ack) begin
            recip_done   = 1'b1;
            recip_result = 64'h0123_4567_89AB_CDEF;
            late_ack     = late_req;
        end else if (pend && cyc == done_cyc) begin
            recip_done   = 1'b1;
            recip_result = recip_model(pd);
            pend         = 1'b0;
        end
        if (reset_n && recip_start && recip_mode == 0) begin
            pend     = 1'b1;
            done_cyc = cyc + 5;
            pd       = recip_d;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dchk(input string nm, input logic [63:0] a, input logic [63:0] e, input int tol);
        d_name = nm; d_act = a; d_exp = e; d_tol = tol;
        d_req++;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [63:0] d, input logic [TAG_W-1:0] tag);
        req_d[i*64 +: 64]       = d;
        req_tag[i*TAG_W +: TAG_W] = tag;
        req_valid[i]            = 1'b1;
    endtask

    task automatic wait_acc(input int target);
        int b = 0;
        while (gq.size() < target && b < 200) begin tick(1); b++; end
        if (gq.size() < target) dchk("wait_accept", 64'(gq.size()), 64'(target), 0);
    endtask

    task automatic wait_served(input int target);
        int b = 0;
        while (served < target && b < 300) begin tick(1); b++; end
        if (served < target) dchk("wait_response", 64'(served), 64'(target), 0);
    endtask

    task automatic wait_rv();
        int b = 0;
        while (!resp_valid && b < 60) begin tick(1); b++; end
        if (!resp_valid) dchk("wait_resp_valid", 64'(resp_valid), 64'd1, 0);
    endtask

    task automatic single(input int i, input logic [63:0] d, input logic [TAG_W-1:0] tag);
        int n;
        int s;
        n = gq.size();
        s = served;
        set_req(i, d, tag);
        wait_acc(n + 1);
        req_valid[i] = 1'b0;
        wait_served(s + 1);
    endtask

    int n;
    int s;
    int exp4[5]  = '{0, 1, 2, 3, 0};
    int exp13[4] = '{1, 3, 1, 3};

    initial begin
        reset_n = 1'b0; req_valid = '0; req_d = '0; req_tag = '0; resp_ready = 1'b1;
        tick(3);
        dchk("pin_seed0", seed_model(0), 64'd34937015291116575, 0);
        dchk("pin_seed8", seed_model(8), 64'd23529010298098918, 0);
        dchk("pin_recip_1p0", recip_model(ONE), ONE, 0);
        dchk("pin_recip_1p5", recip_model(ONE5), 64'h0055_5555_5555_5555, 0);
        reset_n = 1'b1;
        tick(2);

        single(0, ONE, 4'h3);
        dchk("t1_data", last_data, ONE, 32);
        dchk("t1_id", 64'(last_id), 64'd0, 0);
        dchk("t1_err", 64'(last_err), 64'd0, 0);
        dchk("t1_latency", 64'(last_lat), 64'd8, 0);

        single(2, ONE5, 4'hA);
        dchk("t2_seed", last_x, 64'd23529010298098918, 0);
        dchk("t2_data", last_data, 64'h0055_5555_5555_5555, 32);
        dchk("t2_tag", 64'(last_tag), 64'hA, 0);

        s = starts;
        single(1, 64'd0, 4'h5);
        dchk("t3_zero_err", 64'(last_err), 64'd1, 0);
        dchk("t3_zero_latency", 64'(last_lat), 64'd2, 0);
        single(3, 64'h0100_0000_0000_0000, 4'h6);
        dchk("t3_big_err", 64'(last_err), 64'd1, 0);
        dchk("t3_big_data", last_data, 64'd0, 0);
        dchk("t3_no_start", 64'(starts), 64'(s), 0);

        n = gq.size();
        s = served;
        for (int i = 0; i < NREQ; i++) set_req(i, ONE + (64'(i) << 51), TAG_W'(i));
        wait_acc(n + 5);
        req_valid = '0;
        wait_served(s + 5);
        for (int k = 0; k < 5; k++) dchk($sformatf("t4_grant%0d", k), 64'(gq[n+k]), 64'(exp4[k]), 0);
        dchk("t4_spacing", 64'(aq[n+1] - aq[n]), 64'd9, 0);

        n = gq.size();
        s = served;
        set_req(1, ONE + (64'd5 << 51), 4'h1);
        set_req(3, ONE + (64'd9 << 51), 4'h3);
        wait_acc(n + 4);
        req_valid = '0;
        wait_served(s + 4);
        for (int k = 0; k < 4; k++) dchk($sformatf("t4b_grant%0d", k), 64'(gq[n+k]), 64'(exp13[k]), 0);

        resp_ready = 1'b0;
        n = gq.size();
        s = starts;
        set_req(1, ONE + (64'd3 << 51), 4'hC);
        set_req(2, ONE + (64'd12 << 51), 4'hD);
        wait_acc(n + 1);
        req_valid[1] = 1'b0;
        wait_rv();
        tick(10);
        resp_ready = 1'b1;
        wait_acc(n + 2);
        req_valid[2] = 1'b0;
        dchk("t5_next_grant_gap", 64'(last_acc - last_hs), 64'd1, 0);
        dchk("t5_grant_id", 64'(gq[n+1]), 64'd2, 0);
        wait_served(served + 1);
        dchk("t5_starts", 64'(starts), 64'(s + 2), 0);

        recip_mode = 1;
        resp_ready = 1'b0;
        n = gq.size();
        set_req(0, ONE + (64'd7 << 51), 4'h7);
        wait_acc(n + 1);
        req_valid[0] = 1'b0;
        wait_rv();
        late_req++;
        tick(3);
        resp_ready = 1'b1;
        tick(1);
        dchk("t6_err", 64'(last_err), 64'd1, 0);
        dchk("t6_data", last_data, 64'd0, 0);
        dchk("t6_latency", 64'(last_lat), 64'(3 + TIMEOUT_CYC), 0);
        late_req++;
        tick(4);
        recip_mode = 0;

        n = gq.size();
        s = starts;
        set_req(1, ONE + (64'd10 << 51), 4'h9);
        wait_acc(n + 1);
        req_valid[1] = 1'b0;
        while (starts == s) tick(1);
        #2;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(5);
        n = gq.size();
        s = served;
        set_req(0, ONE + (64'd2 << 51), 4'hE);
        set_req(3, ONE + (64'd4 << 51), 4'hF);
        wait_acc(n + 1);
        req_valid = '0;
        wait_served(s + 1);
        dchk("t7_grant_after_reset", 64'(gq[n]), 64'd0, 0);
        dchk("t7_err", 64'(last_err), 64'd0, 0);
        dchk("t7_data", last_data, recip_model(ONE + (64'd2 << 51)), 32);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual still running, required finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
